// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the push-button debouncer: channel FSM states and
// default debounce lengths for the 12 MHz board and for simulation.
package button_debouncer_pkg;

  typedef enum logic [1:0] {
    ST_STABLE_LOW  = 2'd0,
    ST_WAIT_HIGH   = 2'd1,
    ST_STABLE_HIGH = 2'd2,
    ST_WAIT_LOW    = 2'd3
  } db_state_t;

  // 10 ms at 12 MHz
  localparam int unsigned DEBOUNCE_CYCLES_12MHZ = 120000;
  localparam int unsigned DEBOUNCE_CYCLES_SIM   = 4;

endpackage

// File: rtl/button_debouncer_channel.sv
// One button channel: 2-FF synchroniser, debounce FSM and run-length counter,
// with registered level and one-cycle rise/fall pulses.
module button_debouncer_channel
  import button_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic btn_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // cnt includes the sample that left the stable state, so the run is complete
  // when the DEBOUNCE_CYCLES-th disagreeing sample arrives with cnt one short.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_q, btn_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= ST_STABLE_LOW;
      cnt_q   <= '0;
      btn_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      btn_q   <= btn_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Next-state, counter and pulse logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    btn_d   = btn_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      ST_STABLE_LOW: begin
        if (sync2_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = ST_STABLE_HIGH;
            btn_d   = 1'b1;
            rise_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = ST_WAIT_HIGH;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (!sync2_q) begin
          state_d = ST_STABLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_STABLE_HIGH;
          btn_d   = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STABLE_HIGH: begin
        if (!sync2_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = ST_STABLE_LOW;
            btn_d   = 1'b0;
            fall_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = ST_WAIT_LOW;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      ST_WAIT_LOW: begin
        if (sync2_q) begin
          state_d = ST_STABLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_STABLE_LOW;
          btn_d   = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_STABLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  assign btn_o  = btn_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/button_debouncer.sv
// Debounces N_BTN independent push-buttons (btn_o[0] -> A, btn_o[1] -> B);
// one self-contained channel per button.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int unsigned N_BTN           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_12MHZ
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_i,
  output logic [N_BTN-1:0] btn_o,
  output logic [N_BTN-1:0] rise_o,
  output logic [N_BTN-1:0] fall_o
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_debouncer_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .btn_i (btn_i[i]),
      .btn_o (btn_o[i]),
      .rise_o(rise_o[i]),
      .fall_o(fall_o[i])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer (N_BTN=2, DEBOUNCE_CYCLES=4):
// directed sequences, a vector table and random stimulus against a run-length model.
module tb_button_debouncer;

  localparam int unsigned N = 2;
  localparam int unsigned D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn = '0;
  logic [N-1:0] btn_o, rise_o, fall_o;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: delay line for the two synchroniser stages plus,
  // per channel, the accepted level and the length of the current disagreeing run.
  logic [N-1:0] hist[$];
  logic [N-1:0] m_level = '0;
  logic [N-1:0] m_rise  = '0;
  logic [N-1:0] m_fall  = '0;
  int           m_run[N];

  typedef struct {
    logic         rst;
    logic [N-1:0] btn;
    int unsigned  hold;
    logic [N-1:0] exp_btn;
  } vec_t;
  vec_t vecs[10];

  button_debouncer #(
    .N_BTN(N),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .btn_i (btn),
    .btn_o (btn_o),
    .rise_o(rise_o),
    .fall_o(fall_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic model_edge(input logic r, input logic [N-1:0] b);
    logic [N-1:0] s;
    m_rise = '0;
    m_fall = '0;
    if (r) begin
      hist.delete();
      hist.push_back('0);
      hist.push_back('0);
      m_level = '0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
    end else begin
      s = hist.pop_front();
      hist.push_back(b);
      for (int i = 0; i < N; i++) begin
        if (s[i] != m_level[i]) m_run[i]++;
        else m_run[i] = 0;
        if (m_run[i] == int'(D)) begin
          m_level[i] = s[i];
          if (s[i]) m_rise[i] = 1'b1;
          else m_fall[i] = 1'b1;
          m_run[i] = 0;
        end
      end
    end
  endtask

  // One clock edge: advance the model with the inputs seen at the edge, then compare
  task automatic tick();
    logic         r;
    logic [N-1:0] b;
    @(posedge clk);
    r = rst;
    b = btn;
    model_edge(r, b);
    #1;
    check("model btn_o", btn_o, m_level);
    check("model rise_o", rise_o, m_rise);
    check("model fall_o", fall_o, m_fall);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int rises;
    int pulses0;
    logic first0;

    hist.push_back('0);
    hist.push_back('0);
    for (int i = 0; i < N; i++) m_run[i] = 0;

    vecs[0] = '{1'b0, 2'b01, 6, 2'b01};
    vecs[1] = '{1'b0, 2'b00, 3, 2'b01};
    vecs[2] = '{1'b0, 2'b00, 3, 2'b00};
    vecs[3] = '{1'b0, 2'b10, 5, 2'b00};
    vecs[4] = '{1'b0, 2'b10, 1, 2'b10};
    vecs[5] = '{1'b0, 2'b11, 6, 2'b11};
    vecs[6] = '{1'b1, 2'b11, 1, 2'b00};
    vecs[7] = '{1'b0, 2'b11, 5, 2'b00};
    vecs[8] = '{1'b0, 2'b11, 1, 2'b11};
    vecs[9] = '{1'b0, 2'b00, 6, 2'b00};

    // Reset, then idle low
    rst = 1'b1;
    tick();
    check("reset btn_o", btn_o, 2'b00);
    check("reset rise_o", rise_o, 2'b00);
    check("reset fall_o", fall_o, 2'b00);
    rst = 1'b0;
    rises = 0;
    for (int e = 0; e < 20; e++) begin
      tick();
      if ((rise_o | fall_o) != 2'b00) rises++;
    end
    check("idle btn_o", btn_o, 2'b00);
    check("idle no pulses", 2'(rises), 2'd0);

    // Clean press on channel 0
    btn = 2'b01;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e < 6) check("press pre-accept", btn_o, 2'b00);
    end
    check("press btn_o edge6", btn_o, 2'b01);
    check("press rise_o edge6", rise_o, 2'b01);
    tick();
    check("press rise one cycle", rise_o, 2'b00);
    check("press btn_o held", btn_o, 2'b01);
    btn = 2'b00;
    ticks(5);
    check("release pre-accept", btn_o, 2'b01);
    tick();
    check("release btn_o edge6", btn_o, 2'b00);
    check("release fall_o edge6", fall_o, 2'b01);
    tick();
    check("release fall one cycle", fall_o, 2'b00);

    // Glitch: high 3, low 1, then held high
    btn = 2'b01;
    ticks(3);
    btn = 2'b00;
    tick();
    check("glitch no change", btn_o, 2'b00);
    btn = 2'b01;
    rises = 0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (rise_o[0]) rises++;
      if (e < 6) check("glitch pre-accept", btn_o, 2'b00);
      if (e == 6) check("glitch btn_o edge6", btn_o, 2'b01);
    end
    check("glitch single rise", 2'(rises), 2'd1);
    btn = 2'b00;
    ticks(8);

    // Both channels together
    btn = 2'b11;
    ticks(5);
    check("both pre-accept", btn_o, 2'b00);
    tick();
    check("both btn_o edge6", btn_o, 2'b11);
    check("both rise_o edge6", rise_o, 2'b11);
    btn = 2'b00;
    ticks(5);
    check("both release pre", btn_o, 2'b11);
    tick();
    check("both fall_o edge6", fall_o, 2'b11);
    check("both btn_o low", btn_o, 2'b00);
    tick();
    check("both fall one cycle", fall_o, 2'b00);

    // Reset mid-count on channel 1
    btn = 2'b10;
    ticks(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midreset btn_o", btn_o, 2'b00);
    check("midreset rise_o", rise_o, 2'b00);
    ticks(5);
    check("midreset pre-accept", btn_o, 2'b00);
    tick();
    check("midreset btn_o edge6", btn_o, 2'b10);
    check("midreset rise_o edge6", rise_o, 2'b10);
    btn = 2'b00;
    ticks(8);

    // Fast toggling on channel 0 never qualifies
    first0 = btn_o[0];
    pulses0 = 0;
    for (int e = 0; e < 50; e++) begin
      btn[0] = ~btn[0];
      tick();
      if (rise_o[0] || fall_o[0] || (btn_o[0] != first0)) pulses0++;
    end
    check("toggle no activity", 2'(pulses0), 2'd0);
    btn = 2'b00;
    ticks(8);

    // Vector table
    for (int k = 0; k < 10; k++) begin
      rst = vecs[k].rst;
      btn = vecs[k].btn;
      ticks(int'(vecs[k].hold));
      check($sformatf("vec%0d btn_o", k), btn_o, vecs[k].exp_btn);
    end
    rst = 1'b0;

    // Random stimulus with occasional resets
    for (int e = 0; e < 800; e++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) btn[i] = ~btn[i];
      rst = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
